// File: rtl/dht_disp_pkg.sv
// Shared definitions for the DHT11 display path: converter states, the
// decoder blank code and the double-dabble nibble adjust.
package dht_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_CODE = 8'hFF;
    localparam int         BCD_ITER   = 8;

    // A BCD nibble never exceeds 9 here, so the sum fits in 4 bits.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/dht_bin2bcd.sv
// Iterative double-dabble converter: one DHT11 byte in, three decoder-ready
// digit codes out after 8 shift cycles, with optional leading-zero blanking.
module dht_bin2bcd
    import dht_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    input  logic       blank_lz,
    output logic       busy,
    output logic       done,
    output logic [7:0] digit2,
    output logic [7:0] digit1,
    output logic [7:0] digit0
);

    localparam logic [2:0] LAST_ITER = 3'(BCD_ITER - 1);

    state_t      state;
    logic [11:0] scratch;
    logic [7:0]  shreg;
    logic [2:0]  cnt;
    logic        blank_q;

    logic [11:0] adj;
    logic [19:0] nxt;
    logic [3:0]  nib_h, nib_t, nib_o;
    logic [7:0]  d2, d1, d0;

    always_comb begin
        adj   = {add3_if_ge5(scratch[11:8]),
                 add3_if_ge5(scratch[7:4]),
                 add3_if_ge5(scratch[3:0])};
        nxt   = {adj, shreg} << 1;
        nib_h = nxt[19:16];
        nib_t = nxt[15:12];
        nib_o = nxt[11:8];
        d2    = {4'h0, nib_h};
        d1    = {4'h0, nib_t};
        d0    = {4'h0, nib_o};
        // Only leading zeros go dark; the ones digit always shows.
        if (blank_q && (nib_h == 4'd0)) begin
            d2 = BLANK_CODE;
            if (nib_t == 4'd0)
                d1 = BLANK_CODE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            digit2  <= 8'h00;
            digit1  <= 8'h00;
            digit0  <= 8'h00;
            scratch <= 12'h000;
            shreg   <= 8'h00;
            cnt     <= 3'd0;
            blank_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        shreg   <= bin;
                        blank_q <= blank_lz;
                        scratch <= 12'h000;
                        cnt     <= 3'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= nxt[19:8];
                    shreg   <= nxt[7:0];
                    cnt     <= cnt + 3'd1;
                    // Digits are loaded from the final step directly, so
                    // partial scratch values never reach the outputs.
                    if (cnt == LAST_ITER) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        digit2 <= d2;
                        digit1 <= d1;
                        digit0 <= d0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_bin2bcd.sv
// Bench for dht_bin2bcd: event-level reference model checked every cycle,
// directed scenarios with literal digit expectations, then random traffic.
module tb_dht_bin2bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bin;
    logic       blank_lz;
    logic       busy;
    logic       done;
    logic [7:0] digit2, digit1, digit0;

    dht_bin2bcd dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .digit2   (digit2),
        .digit1   (digit1),
        .digit0   (digit0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division, then leading-zero blanking.
    function automatic logic [23:0] ref_digits(input int v, input logic bl);
        int h, t, o;
        logic [7:0] e2, e1, e0;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        e2 = 8'(h);
        e1 = 8'(t);
        e0 = 8'(o);
        if (bl && h == 0) begin
            e2 = 8'hFF;
            if (t == 0) e1 = 8'hFF;
        end
        return {e2, e1, e0};
    endfunction

    // Reference: an accepted request yields its result 9 edges later;
    // requests are only accepted when nothing is in flight.
    int          remain = 0;
    logic [7:0]  pbin   = 8'h00;
    logic        pbl    = 1'b0;
    logic        m_done = 1'b0;
    logic [23:0] m_dig  = 24'h0;

    always @(posedge clk) begin
        if (rst) begin
            remain = 0;
            m_done = 1'b0;
            m_dig  = 24'h0;
        end else begin
            m_done = 1'b0;
            if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    m_done = 1'b1;
                    m_dig  = ref_digits(int'(pbin), pbl);
                end
            end else if (start) begin
                remain = 8;
                pbin   = bin;
                pbl    = blank_lz;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   {7'b0, busy}, {7'b0, remain > 0});
            chk("done",   {7'b0, done}, {7'b0, m_done});
            chk("digit2", digit2, m_dig[23:16]);
            chk("digit1", digit1, m_dig[15:8]);
            chk("digit0", digit0, m_dig[7:0]);
        end
    end

    task automatic run(input logic [7:0] v, input logic bl, output int lat);
        @(negedge clk);
        start = 1'b1; bin = v; blank_lz = bl;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_digits(input string nm, input logic [23:0] exp);
        chk({nm, "_d2"}, digit2, exp[23:16]);
        chk({nm, "_d1"}, digit1, exp[15:8]);
        chk({nm, "_d0"}, digit0, exp[7:0]);
    endtask

    initial begin
        int lat, ndone, dcyc, dcyc2;
        logic [23:0] cap, cap2;

        rst = 1'b1; start = 1'b0; bin = 8'h00; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        chk_digits("rst", 24'h000000);
        rst = 1'b0;

        run(8'd255, 1'b0, lat);
        chk("max_latency", 8'(lat), 8'd9);
        chk_digits("max", 24'h020505);

        run(8'd0, 1'b1, lat);
        chk_digits("zero_bl", 24'hFFFF00);
        run(8'd0, 1'b0, lat);
        chk_digits("zero_nobl", 24'h000000);
        run(8'd37, 1'b1, lat);
        chk_digits("d37_bl", 24'hFF0307);
        run(8'd100, 1'b1, lat);
        chk_digits("d100_bl", 24'h010000);

        // Second request arrives mid-conversion and must be ignored.
        @(negedge clk);
        start = 1'b1; bin = 8'd42; blank_lz = 1'b0;
        ndone = 0; dcyc = 0; cap = 24'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin ndone++; dcyc = c; cap = {digit2, digit1, digit0}; end
            start = (c == 4);
            if (c == 4) bin = 8'd99;
        end
        chk("busy_ndone", 8'(ndone), 8'd1);
        chk("busy_dcyc", 8'(dcyc), 8'd9);
        chk("busy_dig", cap[7:0], 8'h02);
        chk("busy_dig1", cap[15:8], 8'h04);

        // Back-to-back with start held.
        @(negedge clk);
        start = 1'b1; bin = 8'd12; blank_lz = 1'b0;
        ndone = 0; dcyc = 0; dcyc2 = 0; cap = 24'h0; cap2 = 24'h0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin dcyc = c; cap = {digit2, digit1, digit0}; bin = 8'd200; end
                else begin dcyc2 = c; cap2 = {digit2, digit1, digit0}; end
            end
            if (c >= 18) start = 1'b0;
        end
        chk("b2b_ndone", 8'(ndone), 8'd2);
        chk("b2b_c1", 8'(dcyc), 8'd9);
        chk("b2b_c2", 8'(dcyc2), 8'd18);
        chk("b2b_dig1", cap[23:16] ^ cap[15:8] ^ cap[7:0], 8'h03);
        chk("b2b_tens1", cap[15:8], 8'h01);
        chk("b2b_ones1", cap[7:0], 8'h02);
        chk("b2b_hund2", cap2[23:16], 8'h02);
        chk("b2b_low2", cap2[15:8] | cap2[7:0], 8'h00);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1; bin = 8'd255; blank_lz = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
            start = 1'b0;
            rst = (c == 5);
        end
        chk("rstmid_ndone", 8'(ndone), 8'd0);
        chk_digits("rstmid", 24'h000000);
        run(8'd73, 1'b0, lat);
        chk("rstmid_lat", 8'(lat), 8'd9);
        chk_digits("after_rst", 24'h000703);

        // Random traffic, including stray starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            bin      = 8'($urandom);
            blank_lz = 1'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
